// File: rtl/meas_scheduler_if.sv
// ---------------------------------------------------------------------------
// meas_scheduler_if
//
// Purpose:
//   Bundles the control, event-input and result signals of meas_scheduler so
//   the scheduler and its surroundings connect through a single port.
//
// Signals:
//   start       sweep start pulse (master -> slave)
//   stop        stop-continuous pulse (master -> slave)
//   continuous  restart the sweep after the last channel (master -> slave)
//   ch_mask     channel enables, NCH bits (master -> slave)
//   window_len  counting window length, WIN_W bits (master -> slave)
//   ch_in       synchronous event inputs, NCH bits (master -> slave)
//   sel         one-hot channel currently gated (slave -> master)
//   value       event count of the reported window (slave -> master)
//   ch_id       channel index of value (slave -> master)
//   ovf         count saturated in the reported window (slave -> master)
//   valid       one-cycle strobe qualifying value/ch_id/ovf (slave -> master)
//   busy        scheduler not idle (slave -> master)
//
// Modports:
//   master  drives control and events, observes results
//   slave   the scheduler side
// ---------------------------------------------------------------------------
interface meas_scheduler_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 12,
    parameter int WIN_W = 16
);
    localparam int CH_W = $clog2(NCH);

    logic             start;
    logic             stop;
    logic             continuous;
    logic [NCH-1:0]   ch_mask;
    logic [WIN_W-1:0] window_len;
    logic [NCH-1:0]   ch_in;

    logic [NCH-1:0]   sel;
    logic [CNT_W-1:0] value;
    logic [CH_W-1:0]  ch_id;
    logic             ovf;
    logic             valid;
    logic             busy;

    modport master (
        output start, stop, continuous, ch_mask, window_len, ch_in,
        input  sel, value, ch_id, ovf, valid, busy
    );

    modport slave (
        input  start, stop, continuous, ch_mask, window_len, ch_in,
        output sel, value, ch_id, ovf, valid, busy
    );
endinterface

// File: rtl/meas_scheduler.sv
// ---------------------------------------------------------------------------
// meas_scheduler
//
// Purpose:
//   Time-shares a single gated rising-edge counter between NCH event inputs.
//   A sweep visits the enabled channels in ascending index order; for each
//   one it gates the channel, waits SETTLE idle cycles, counts rising edges
//   for a fixed window and then reports the count with the channel index and
//   a one-cycle valid strobe. In continuous mode the sweep restarts after the
//   last channel until a stop request is seen.
//
// Parameters:
//   NCH     number of event channels (>= 2)
//   CNT_W   event counter / result width
//   WIN_W   window length width
//   SETTLE  idle cycles after a channel switch before counting (>= 1)
//
// Ports:
//   clk   single clock, all logic on the rising edge
//   rst   asynchronous active-high reset
//   bus   meas_scheduler_if slave modport:
//           in : start, stop, continuous, ch_mask, window_len, ch_in
//           out: sel, value, ch_id, ovf, valid, busy
// ---------------------------------------------------------------------------
module meas_scheduler #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 12,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    meas_scheduler_if.slave bus
);

    localparam int CH_W  = $clog2(NCH);
    // The settle timer only has to hold SETTLE-1.
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_COUNT  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;

    // Sweep configuration, frozen for the duration of a sweep
    logic [NCH-1:0]   mask_lat;
    logic [WIN_W-1:0] win_lat;
    logic             cont_lat;
    logic             stop_req;

    // Channel scan position and currently gated channel
    logic [CH_W-1:0]  ptr;
    logic [CH_W-1:0]  cur;

    // Phase timers
    logic [SET_W-1:0] settle_cnt;
    logic [WIN_W-1:0] win_cnt;

    // Gated counter and its edge detector
    logic [CNT_W-1:0] counter;
    logic             cnt_ovf;
    logic             prev_in;

    // Registered result outputs
    logic [CNT_W-1:0] value_r;
    logic [CH_W-1:0]  ch_id_r;
    logic             ovf_r;
    logic             valid_r;

    // Combinational helpers
    logic [WIN_W-1:0] win_in_eff;
    logic             start_ok;
    logic             restart;
    logic             cur_in;
    logic             rise;
    logic [CH_W-1:0]  scan_idx;
    logic             has_higher;

    // A zero window length is treated as a one-cycle window.
    assign win_in_eff = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
    assign start_ok   = bus.start && (bus.ch_mask != '0);
    // A stop arriving in the REPORT cycle itself also ends continuous mode.
    assign restart    = cont_lat && !(stop_req || bus.stop);
    assign cur_in     = bus.ch_in[cur];
    assign rise       = cur_in && !prev_in;

    // Lowest enabled channel at or above the scan pointer. Scanning from the
    // top down lets the last hit (the lowest index) win.
    always_comb begin
        scan_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_lat[i] && (CH_W'(i) >= ptr)) begin
                scan_idx = CH_W'(i);
            end
        end
    end

    // Whether any enabled channel remains above the one just measured.
    always_comb begin
        has_higher = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mask_lat[i] && (CH_W'(i) > cur)) begin
                has_higher = 1'b1;
            end
        end
    end

    // Next-state logic. A continuous restart with an all-zero mask drops
    // straight back to IDLE instead of entering SELECT with nothing to scan.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (win_cnt == '0) begin
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (has_higher) begin
                    state_nxt = S_SELECT;
                end else if (restart && (bus.ch_mask != '0)) begin
                    state_nxt = S_SELECT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep configuration and channel pointer. Configuration is only sampled
    // at sweep start and at a continuous restart, so mid-sweep changes on the
    // inputs are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_lat <= '0;
            win_lat  <= '0;
            cont_lat <= 1'b0;
            ptr      <= '0;
            cur      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        mask_lat <= bus.ch_mask;
                        win_lat  <= win_in_eff;
                        cont_lat <= bus.continuous;
                        ptr      <= '0;
                    end
                end
                S_SELECT: begin
                    cur <= scan_idx;
                end
                S_REPORT: begin
                    if (has_higher) begin
                        ptr <= cur + CH_W'(1);
                    end else if (restart) begin
                        mask_lat <= bus.ch_mask;
                        win_lat  <= win_in_eff;
                        ptr      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stop request: cleared by an accepted start (start beats a simultaneous
    // stop), set by any stop while a sweep is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_req <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start_ok) begin
                stop_req <= 1'b0;
            end
        end else if (bus.stop) begin
            stop_req <= 1'b1;
        end
    end

    // Settle and window timers count down to zero; the phase ends on the
    // cycle the timer reads zero, giving exactly SETTLE and W cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
        end else begin
            case (state)
                S_SELECT: begin
                    settle_cnt <= SET_W'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end else begin
                        win_cnt <= win_lat - WIN_W'(1);
                    end
                end
                S_COUNT: begin
                    if (win_cnt != '0) begin
                        win_cnt <= win_cnt - WIN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Gated edge counter. The edge detector is primed during SETTLE so a
    // level already high when counting begins is not seen as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            cnt_ovf <= 1'b0;
            prev_in <= 1'b0;
        end else begin
            case (state)
                S_SETTLE: begin
                    counter <= '0;
                    cnt_ovf <= 1'b0;
                    prev_in <= cur_in;
                end
                S_COUNT: begin
                    prev_in <= cur_in;
                    if (rise) begin
                        if (counter == '1) begin
                            cnt_ovf <= 1'b1;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: captured in REPORT, held until the next report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
            ch_id_r <= '0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= (state == S_REPORT);
            if (state == S_REPORT) begin
                value_r <= counter;
                ch_id_r <= cur;
                ovf_r   <= cnt_ovf;
            end
        end
    end

    assign bus.sel   = ((state == S_SETTLE) || (state == S_COUNT)) ?
                       (NCH'(1) << cur) : '0;
    assign bus.value = value_r;
    assign bus.ch_id = ch_id_r;
    assign bus.ovf   = ovf_r;
    assign bus.valid = valid_r;
    assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_meas_scheduler.sv
// ---------------------------------------------------------------------------
// tb_meas_scheduler
//
// Purpose:
//   Self-checking bench for meas_scheduler. Expected reports are queued when
//   a sweep is launched and compared as valid strobes appear; report timing,
//   gating and reset behaviour are checked alongside.
// ---------------------------------------------------------------------------
module tb_meas_scheduler;

    localparam int NCH    = 4;
    localparam int CNT_W  = 12;
    localparam int WIN_W  = 16;
    localparam int SETTLE = 2;

    typedef struct {
        int ch;
        int val;
        int ovf;
    } exp_t;

    logic clk;
    logic rst;

    meas_scheduler_if #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    meas_scheduler #(
        .NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   start_cyc   = 0;
    exp_t sb[$];
    int   vcyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Report monitor: every valid strobe must match the head of the queue.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            exp_t e;
            vcyc.push_back(cyc);
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("rep_ch_id", 32'(bus.ch_id), e.ch);
                checkOutput("rep_value", 32'(bus.value), e.val);
                checkOutput("rep_ovf",   32'(bus.ovf),   e.ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start pulse with the given configuration.
    task automatic pulseStart(input logic [NCH-1:0] mask,
                              input logic [WIN_W-1:0] wlen, input logic cont);
        bus.start      = 1'b1;
        bus.ch_mask    = mask;
        bus.window_len = wlen;
        bus.continuous = cont;
        tick(1);
        bus.start = 1'b0;
    endtask

    // Launch a sweep and remember the edge that sampled the start.
    task automatic applyStimulus(input logic [NCH-1:0] mask,
                                 input logic [WIN_W-1:0] wlen, input logic cont);
        vcyc.delete();
        pulseStart(mask, wlen, cont);
        start_cyc = cyc;
    endtask

    task automatic pushExp(input int ch, input int val, input int ovf);
        exp_t e;
        e.ch  = ch;
        e.val = val;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checkOutput({tag, "_timeout"}, 1, 0);
        end
        repeat (4) @(negedge clk);
        tick(1);
    endtask

    task automatic checkReports(input string tag, input int n_exp,
                                input int first_lat, input int spacing);
        checkOutput({tag, "_n_reports"}, vcyc.size(), n_exp);
        if (vcyc.size() >= 1) begin
            checkOutput({tag, "_latency"}, vcyc[0] - start_cyc, first_lat);
        end
        for (int i = 1; i < vcyc.size(); i++) begin
            checkOutput({tag, "_spacing"}, vcyc[i] - vcyc[i-1], spacing);
        end
        checkOutput({tag, "_sb_drain"}, sb.size(), 0);
        sb.delete();
        checkOutput({tag, "_busy_end"}, 32'(bus.busy), 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_mask    = '0;
        bus.window_len = '0;
        bus.ch_in      = '0;
        tick(3);

        checkOutput("rst_sel",   32'(bus.sel),   0);
        checkOutput("rst_busy",  32'(bus.busy),  0);
        checkOutput("rst_valid", 32'(bus.valid), 0);
        checkOutput("rst_value", 32'(bus.value), 0);
        checkOutput("rst_ch_id", 32'(bus.ch_id), 0);
        checkOutput("rst_ovf",   32'(bus.ovf),   0);
        rst = 1'b0;
        tick(2);

        // Two-channel sweep: ch0 sees three rises, ch2 sits high throughout.
        bus.ch_in = 4'b0100;
        pushExp(0, 3, 0);
        pushExp(2, 0, 0);
        applyStimulus(4'b0101, 16'd10, 1'b0);
        bus.ch_mask    = 4'b1111;
        bus.window_len = 16'd3;
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) checkOutput("t1_sel_ch0", 32'(bus.sel), 32'b0001);
            bus.ch_in[0] = (k == 4 || k == 6 || k == 8);
            tick(1);
        end
        bus.ch_in[0] = 1'b0;
        tick(8);
        checkOutput("t1_sel_ch2", 32'(bus.sel), 32'b0100);
        waitIdle(100, "t1");
        checkReports("t1", 2, SETTLE + 10 + 2, SETTLE + 10 + 2);
        bus.ch_in = '0;

        // Saturation: 5000 rises into a 12-bit counter.
        pushExp(0, 4095, 1);
        applyStimulus(4'b0001, 16'd10000, 1'b0);
        begin
            int n = 0;
            while (bus.busy === 1'b1 && n < 10100) begin
                bus.ch_in[0] = ~bus.ch_in[0];
                tick(1);
                n++;
            end
        end
        bus.ch_in = '0;
        waitIdle(50, "t2");
        checkReports("t2", 1, SETTLE + 10000 + 2, 0);

        // Reset mid-COUNT clears outputs at once and suppresses the report.
        applyStimulus(4'b0110, 16'd50, 1'b0);
        tick(20);
        checkOutput("t5_sel_before", 32'(bus.sel), 32'b0010);
        rst = 1'b1;
        #1;
        checkOutput("t5_sel",   32'(bus.sel),   0);
        checkOutput("t5_busy",  32'(bus.busy),  0);
        checkOutput("t5_value", 32'(bus.value), 0);
        checkOutput("t5_ovf",   32'(bus.ovf),   0);
        checkOutput("t5_valid", 32'(bus.valid), 0);
        tick(3);
        rst = 1'b0;
        tick(2);
        pushExp(0, 0, 0);
        pushExp(1, 0, 0);
        applyStimulus(4'b0011, 16'd5, 1'b0);
        waitIdle(100, "t5");
        checkReports("t5", 2, SETTLE + 5 + 2, SETTLE + 5 + 2);

        // Continuous mode on ch3, stopped part-way through the third window.
        pushExp(3, 0, 0);
        pushExp(3, 0, 0);
        pushExp(3, 0, 0);
        applyStimulus(4'b1000, 16'd20, 1'b1);
        tick(60);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        waitIdle(200, "t3");
        tick(30);
        checkReports("t3", 3, 24, 24);

        // Start with an empty mask is ignored.
        pulseStart(4'b0000, 16'd10, 1'b0);
        tick(3);
        checkOutput("t4_mask0_busy", 32'(bus.busy), 0);
        checkOutput("t4_mask0_sel",  32'(bus.sel),  0);

        // Zero window length, with a second start while busy.
        pushExp(0, 0, 0);
        applyStimulus(4'b0001, 16'd0, 1'b0);
        pulseStart(4'b0010, 16'd5, 1'b0);
        waitIdle(100, "t4");
        tick(20);
        checkReports("t4", 1, 5, 0);

        // Rise in the last SETTLE sample is ignored; rise in the last COUNT
        // sample is counted.
        pushExp(0, 1, 0);
        applyStimulus(4'b0001, 16'd8, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            bus.ch_in[0] = ((k >= 3 && k <= 9) || k == 11);
            tick(1);
        end
        bus.ch_in = '0;
        waitIdle(100, "t6");
        checkReports("t6", 1, SETTLE + 8 + 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
